// File: rtl/mux_n_skid.sv
// N-way channel mux feeding a 2-entry skid buffer with registered in_ready.
// Define MUX_N_SKID_MERGE_EN to drive bitwise-merged data on an invalid select.
module mux_n_skid #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int SELW  = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SELW-1:0]        in_sel,
   input  logic [NCH*WIDTH-1:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_err
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_data_q, main_data_d;
   logic             main_err_q, main_err_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             skid_err_q, skid_err_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [WIDTH-1:0] beat_data;
   logic             beat_err;
   logic             in_xfer;
   logic             out_xfer;

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = out_valid_q & out_ready;

   // Invalid selects fall through to the default, valid ones override it
   always_comb begin
`ifdef MUX_N_SKID_MERGE_EN
      beat_data = '1;
      for (int k = 0; k < NCH; k++) begin
         beat_data = beat_data & in_data[k*WIDTH +: WIDTH];
      end
`else
      beat_data = '0;
`endif
      beat_err = ({1'b0, in_sel} >= NCH_L);
      for (int k = 0; k < NCH; k++) begin
         if ({1'b0, in_sel} == (SELW+1)'(k)) begin
            beat_data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_err_d  = main_err_q;
      skid_data_d = skid_data_q;
      skid_err_d  = skid_err_q;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d     = ONE;
               main_data_d = beat_data;
               main_err_d  = beat_err;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               main_data_d = beat_data;
               main_err_d  = beat_err;
            end else if (in_xfer) begin
               state_d     = FULL;
               skid_data_d = beat_data;
               skid_err_d  = beat_err;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               state_d     = ONE;
               main_data_d = skid_data_q;
               main_err_d  = skid_err_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_err_q  <= 1'b0;
         skid_data_q <= '0;
         skid_err_q  <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_err_q  <= main_err_d;
         skid_data_q <= skid_data_d;
         skid_err_q  <= skid_err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_data_q;
   assign out_err   = main_err_q;

endmodule

// File: doc/mux_n_skid.md
MUX_N_SKID -- requirements
Module: mux_n_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width per channel in bits (1..64).
REQ-002 SHALL have parameter NCH, default 4, meaning number of input channels (2..16).
REQ-003 SHALL have parameter SELW, default 2, meaning select width in bits; it SHALL satisfy 2**SELW >= NCH.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit; reset is synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning the upstream beat is valid.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the block can accept a beat.
REQ-008 SHALL have port in_sel, input, SELW bits, meaning the channel index for this beat.
REQ-009 SHALL have port in_data, input, NCH*WIDTH bits; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid, output, 1 bit, meaning the output beat is valid.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning downstream accepts the beat.
REQ-012 SHALL have port out_data, output, WIDTH bits, carrying the selected channel data.
REQ-013 SHALL have port out_err, output, 1 bit, meaning in_sel >= NCH for this beat; it is valid only while out_valid is 1.

Function
REQ-014 An input transfer SHALL occur when in_valid=1 and in_ready=1 on a rising clk edge; an output transfer SHALL occur when out_valid=1 and out_ready=1.
REQ-015 SHALL compute each beat as {err = (in_sel >= NCH), data = channel in_sel}, captured at the input transfer.
REQ-016 Latency SHALL be 1 cycle: a beat accepted at edge t SHALL appear on out_* after edge t, with no combinational path from in_* to out_*.
REQ-017 SHALL hold beats in a 2-entry skid buffer (main + skid) with states EMPTY, ONE and FULL.
REQ-018 in_ready SHALL be a register output equal to 1 in EMPTY and ONE, and 0 in FULL; it SHALL not depend combinationally on out_ready.
REQ-019 EMPTY + input transfer -> ONE; the beat goes to main.
REQ-020 ONE + input transfer only -> FULL; the new beat goes to skid.
REQ-021 ONE + output transfer only -> EMPTY.
REQ-022 ONE + simultaneous input and output transfer -> ONE; main is replaced by the new beat.
REQ-023 FULL + output transfer -> ONE; the skid beat moves to main. No input is accepted while FULL.
REQ-024 out_valid SHALL be 1 exactly in ONE and FULL; out_data and out_err SHALL always reflect main.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_err SHALL be held stable.
REQ-026 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-027 in_sel and in_data SHALL be ignored when no input transfer occurs.

Reset
REQ-028 When reset_n=0 at a rising edge, the block SHALL enter EMPTY with out_valid=0, out_data=0, out_err=0 and in_ready=0.
REQ-029 in_ready SHALL rise to 1 on the first edge with reset_n=1.
REQ-030 Reset asserted mid-operation SHALL discard all held beats on that edge, including a beat offered in the same cycle.

Configuration
REQ-031 Macro MUX_N_SKID_MERGE_EN SHALL select the data driven on an invalid select (in_sel >= NCH).
REQ-032 With MUX_N_SKID_MERGE_EN defined, for an invalid select each out_data bit SHALL equal the common value when that bit is identical across all NCH channels, and 0 otherwise.
REQ-033 Without MUX_N_SKID_MERGE_EN, an invalid select SHALL produce out_data=0.
REQ-034 out_err=1 SHALL be produced for an invalid select in both configurations.

Verification
REQ-035 Reset then single beat: sel=2, ch2=8'hA5, out_ready=1 -> out_valid=1, out_data=8'hA5 and out_err=0 one cycle later; then EMPTY.
REQ-036 Backpressure: out_ready=0 while 3 beats are offered (sel 0,1,3) -> 2 beats accepted, in_ready=0 in FULL, out_data stable; release out_ready -> beats delivered in order 0,1,3.
REQ-037 Streaming: in_valid=1 and out_ready=1 for 16 cycles with incrementing sel -> one beat delivered per cycle, in_ready held at 1, no bubbles.
REQ-038 Invalid select: NCH=3, sel=3, channels 8'hF0, 8'hF3, 8'hFC -> out_err=1; out_data=8'hF0 with the macro defined, 8'h00 without it.
REQ-039 Reset mid-stream: reset_n=0 while in FULL -> on the next edge out_valid=0 and in_ready=0; after release, no stale beats appear.
REQ-040 Randomised: random in_valid and out_ready over 1000 cycles, compared against a reference queue -> no loss, duplication or reordering.
